// File: rtl/ahb_lite_mem_tester_pkg.sv
// Shared AHB-Lite encodings, tester mode codes, FSM state type and LFSR helper.
package ahb_lite_mem_tester_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_X8  = 3'b000;
  localparam logic [2:0] HSIZE_X16 = 3'b001;
  localparam logic [2:0] HSIZE_X32 = 3'b010;
  localparam logic [2:0] HSIZE_X64 = 3'b011;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic [1:0] MODE_INCR = 2'd0;
  localparam logic [1:0] MODE_LFSR = 2'd1;
  localparam logic [1:0] MODE_BYTE = 2'd2;
  localparam logic [1:0] MODE_WALK = 2'd3;

  // Right-shifting Galois form of x^32+x^22+x^2+x+1.
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_WR_DRAIN,
    ST_READ,
    ST_RD_DRAIN,
    ST_DONE,
    ST_ABORT
  } tester_state_e;

  function automatic logic [2:0] word_hsize(input int unsigned data_width);
    return (data_width == 64) ? HSIZE_X64 : HSIZE_X32;
  endfunction

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? LFSR_TAPS : 32'h0);
  endfunction

endpackage

// File: rtl/ahb_lite_tester_pattern.sv
// Pattern generator: pattern word for the current word index/address,
// plus the selected byte replicated over all lanes for byte-lane writes.
module ahb_lite_tester_pattern
  import ahb_lite_mem_tester_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned IDX_WIDTH  = 8,
  parameter logic [31:0] SEED       = 32'h1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [1:0]                        mode,
  input  logic [IDX_WIDTH-1:0]              index,
  input  logic [ADDR_WIDTH-1:0]             word_addr,
  input  logic [$clog2(DATA_WIDTH/8)-1:0]   byte_sel,
  input  logic                              init,
  input  logic                              step,
  output logic [DATA_WIDTH-1:0]             pat,
  output logic [DATA_WIDTH-1:0]             pat_byte
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;

  logic [31:0] lfsr;
  logic [7:0]  byte_val;

  // LFSR holds the pattern of the word currently in its address phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr <= SEED;
    end else if (init) begin
      lfsr <= SEED;
    end else if (step) begin
      lfsr <= lfsr_next(lfsr);
    end
  end

  // Pattern word selected by mode.
  always_comb begin
    pat = '0;
    case (mode)
      MODE_INCR, MODE_BYTE: pat = DATA_WIDTH'(word_addr) ^ DATA_WIDTH'(SEED);
      MODE_LFSR:            pat = {(DATA_WIDTH/32){lfsr}};
      default:              pat = {{(DATA_WIDTH-1){1'b0}}, 1'b1} << (index % DATA_WIDTH);
    endcase
  end

  // Byte k of the pattern, replicated so it lands on lane k whatever the lane.
  always_comb begin
    byte_val = pat[{byte_sel, 3'b000} +: 8];
    pat_byte = {BYTES{byte_val}};
  end

endmodule

// File: rtl/ahb_lite_mem_tester.sv
// AHB-Lite single master: writes a pattern over a window, reads it back,
// and reports pass/fail, mismatch count and first failing address.
module ahb_lite_mem_tester
  import ahb_lite_mem_tester_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int unsigned           WORDS      = 256,
  parameter logic [31:0]           SEED       = 32'h1
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  start,
  input  logic [1:0]            mode,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  resp_err,
  output logic [15:0]           err_count,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  output logic                  HSEL,
  output logic [ADDR_WIDTH-1:0] HADDR,
  output logic [2:0]            HBURST,
  output logic [2:0]            HSIZE,
  output logic [1:0]            HTRANS,
  output logic                  HWRITE,
  output logic [DATA_WIDTH-1:0] HWDATA,
  input  logic [DATA_WIDTH-1:0] HRDATA,
  input  logic                  HREADY,
  input  logic                  HRESP
);

  localparam int unsigned BYTES  = DATA_WIDTH / 8;
  localparam int unsigned BSEL_W = $clog2(BYTES);
  localparam int unsigned IDX_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(WORDS - 1);
  localparam logic [BSEL_W-1:0] LAST_BYTE = BSEL_W'(BYTES - 1);
  localparam logic [2:0]        WORD_SIZE = word_hsize(DATA_WIDTH);

  tester_state_e state, state_next;

  logic [1:0]            run_mode;
  logic [IDX_W-1:0]      word_idx;
  logic [BSEL_W-1:0]     byte_idx;
  logic                  dp_valid;
  logic                  dp_write;
  logic [ADDR_WIDTH-1:0] dp_addr;
  logic [DATA_WIDTH-1:0] dp_expect;
  logic                  mismatch_seen;

  logic                  accept, dp_done, bus_err, last_byte, last_word;
  logic                  start_run, abort_run, pat_init, pat_step;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic [DATA_WIDTH-1:0] pat, pat_byte;

  assign word_addr = {HADDR[ADDR_WIDTH-1:BSEL_W], {BSEL_W{1'b0}}};
  assign busy      = (state != ST_IDLE) && (state != ST_DONE);
  assign done      = (state == ST_DONE);
  assign pass      = done && !resp_err && !mismatch_seen;
  assign HSEL      = busy;
  assign HBURST    = HBURST_SINGLE;

  // Bus handshake qualifiers for the current cycle.
  always_comb begin
    accept    = (HTRANS == HTRANS_NONSEQ) && HREADY;
    dp_done   = dp_valid && HREADY && !HRESP;
    bus_err   = dp_valid && HRESP && (state != ST_ABORT);
    last_byte = (run_mode != MODE_BYTE) || (byte_idx == LAST_BYTE);
    last_word = (word_idx == LAST_IDX);
  end

  // State register.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state and per-cycle control strobes.
  always_comb begin
    state_next = state;
    start_run  = 1'b0;
    abort_run  = 1'b0;
    pat_init   = 1'b0;
    pat_step   = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: if (start) state_next = ST_WRITE;
      ST_WRITE:    if (bus_err) state_next = ST_ABORT;
                   else if (accept && last_byte && last_word) state_next = ST_WR_DRAIN;
      ST_WR_DRAIN: if (bus_err) state_next = ST_ABORT;
                   else if (dp_done) state_next = ST_READ;
      ST_READ:     if (bus_err) state_next = ST_ABORT;
                   else if (accept && last_word) state_next = ST_RD_DRAIN;
      ST_RD_DRAIN: if (bus_err) state_next = ST_ABORT;
                   else if (dp_done) state_next = ST_DONE;
      ST_ABORT:    state_next = ST_DONE;
      default:     state_next = ST_IDLE;
    endcase
    start_run = ((state == ST_IDLE) || (state == ST_DONE)) && start;
    abort_run = bus_err;
    pat_init  = start_run || ((state == ST_WR_DRAIN) && dp_done && !bus_err);
    pat_step  = accept && last_byte && !bus_err &&
                ((state == ST_WRITE) || (state == ST_READ));
  end

  // Address phase, data-phase pipeline register, compare and status.
  // Everything on the bus only moves when HREADY=1, which keeps the
  // address/control/write data stable through slave wait states.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      HADDR          <= '0;
      HTRANS         <= HTRANS_IDLE;
      HWRITE         <= 1'b0;
      HSIZE          <= WORD_SIZE;
      HWDATA         <= '0;
      run_mode       <= MODE_INCR;
      word_idx       <= '0;
      byte_idx       <= '0;
      dp_valid       <= 1'b0;
      dp_write       <= 1'b0;
      dp_addr        <= '0;
      dp_expect      <= '0;
      resp_err       <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      mismatch_seen  <= 1'b0;
    end else if (start_run) begin
      run_mode       <= mode;
      HADDR          <= BASE_ADDR;
      HTRANS         <= HTRANS_NONSEQ;
      HWRITE         <= 1'b1;
      HSIZE          <= (mode == MODE_BYTE) ? HSIZE_X8 : WORD_SIZE;
      word_idx       <= '0;
      byte_idx       <= '0;
      dp_valid       <= 1'b0;
      resp_err       <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      mismatch_seen  <= 1'b0;
    end else if (abort_run) begin
      // Cancel the address waiting behind the errored transfer.
      HTRANS   <= HTRANS_IDLE;
      dp_valid <= 1'b0;
      resp_err <= 1'b1;
    end else if (HREADY) begin
      if (dp_valid && !dp_write && (HRDATA != dp_expect)) begin
        if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
        if (!mismatch_seen) first_err_addr <= dp_addr;
        mismatch_seen <= 1'b1;
      end
      dp_valid  <= accept;
      dp_write  <= HWRITE;
      dp_addr   <= HADDR;
      dp_expect <= pat;
      if (accept && HWRITE) HWDATA <= (run_mode == MODE_BYTE) ? pat_byte : pat;
      case (state)
        ST_WRITE: if (accept) begin
          if (last_byte && last_word) begin
            HTRANS <= HTRANS_IDLE;
          end else begin
            HADDR <= HADDR + ((run_mode == MODE_BYTE) ? ADDR_WIDTH'(1) : ADDR_WIDTH'(BYTES));
            if (last_byte) begin
              byte_idx <= '0;
              word_idx <= word_idx + 1'b1;
            end else begin
              byte_idx <= byte_idx + 1'b1;
            end
          end
        end
        ST_WR_DRAIN: if (dp_done) begin
          HADDR    <= BASE_ADDR;
          HTRANS   <= HTRANS_NONSEQ;
          HWRITE   <= 1'b0;
          HSIZE    <= WORD_SIZE;
          word_idx <= '0;
          byte_idx <= '0;
        end
        ST_READ: if (accept) begin
          if (last_word) begin
            HTRANS <= HTRANS_IDLE;
          end else begin
            HADDR    <= HADDR + ADDR_WIDTH'(BYTES);
            word_idx <= word_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  ahb_lite_tester_pattern #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_WIDTH  (IDX_W),
    .SEED       (SEED)
  ) u_pattern (
    .clk       (HCLK),
    .rst       (HRESET),
    .mode      (run_mode),
    .index     (word_idx),
    .word_addr (word_addr),
    .byte_sel  (byte_idx),
    .init      (pat_init),
    .step      (pat_step),
    .pat       (pat),
    .pat_byte  (pat_byte)
  );

endmodule
